async_fifo_param: RTL and testbench
===================================

// Module: async_fifo_param
// PURPOSE
//  Parametrised dual-clock FIFO; next generation of the team's async FIFO.
//  Moves DATA_WIDTH-bit words from the trans_clk domain to the recv_clk domain.
//  Adds over the previous generation: configurable depth, sync depth and almost-full/empty margins;
//  per-domain fill levels; a registered 1-cycle read port.
// PARAMETERS
//  DATA_WIDTH   8  word width in bits
//  ADDR_WIDTH   4  log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
//  SYNC_STAGES  2  flops per pointer/reset synchronizer; legal values >= 2
//  AF_MARGIN    2  fifo_almost_full when trans_level >= DEPTH-AF_MARGIN
//  AE_MARGIN    2  fifo_almost_empty when recv_level <= AE_MARGIN
// PORTS
//  recv_clk           in   1             read-domain clock
//  trans_clk          in   1             write-domain clock
//  trans_rst          in   1             async active-high reset for both domains
//  write_enable       in   1             write request (trans_clk)
//  trans_data         in   DATA_WIDTH    write data
//  fifo_full          out  1             no write accepted (trans_clk)
//  fifo_almost_full   out  1             level threshold flag (trans_clk)
//  trans_level        out  ADDR_WIDTH+1  write-side fill count, 0..DEPTH
//  read_enable        in   1             read request (recv_clk)
//  recv_data          out  DATA_WIDTH    registered read data
//  recv_valid         out  1             recv_data updated this cycle
//  fifo_empty         out  1             no read accepted (recv_clk)
//  fifo_almost_empty  out  1             level threshold flag (recv_clk)
//  recv_level         out  ADDR_WIDTH+1  read-side fill count, 0..DEPTH
// BEHAVIOUR
//  - Reset trans_rst, asynchronous, active-high; clock recv_clk.
//  - trans_clk clocks the write side.
//  - Reset assertion clears both domains immediately.
//  - Deassertion reaches each domain through its own SYNC_STAGES-flop synchronizer.
//  - Reset values: fifo_full=0, fifo_almost_full=0, trans_level=0, recv_data=0, recv_valid=0,
//    fifo_empty=1, fifo_almost_empty=1, recv_level=0.
//  - Write pointers: binary and Gray, ADDR_WIDTH+1 bits.
//  - Write accept: write_enable && !fifo_full. mem[wptr] <= trans_data; wptr++ (wraps mod 2*DEPTH).
//  - Read accept: read_enable && !fifo_empty. Next edge: recv_data <= mem[rptr], recv_valid=1, rptr++.
//  - Read latency is 1 recv_clk cycle. recv_data holds its value when no read is accepted.
//  - Gray pointers cross domains through SYNC_STAGES flops.
//  - Flags are registered from next-state pointers:
//    - empty: rgray_next == wgray_synced.
//    - full: wgray_next == {~rgray_sync[MSB:MSB-1], rgray_sync[MSB-2:0]}.
//  - trans_level = wbin - gray2bin(rgray_synced), pessimistic (never under true count).
//  - recv_level = gray2bin(wgray_synced) - rbin, pessimistic (never over true count).
//  - Write while full, or read while empty: ignored; no pointer, memory or data change.
//  - Simultaneous read and write at any level are both legal; the word written at level 0
//    becomes readable SYNC_STAGES+1 recv_clk edges after its write.
//  - Reset mid-operation discards all stored words; memory array is not cleared.
//    The first word written after reset is the first word read.
// CONFIGURATION
//  ASYNC_FIFO_ERR_FLAGS_EN defined:
//   - Adds outputs overflow (trans_clk) and underflow (recv_clk), reset 0.
//   - overflow sets sticky on write_enable && fifo_full.
//   - underflow sets sticky on read_enable && fifo_empty.
//   - Both clear only on trans_rst.
//  ASYNC_FIFO_ERR_FLAGS_EN undefined: those ports and logic are absent; rest is identical.
// TESTING (defaults; trans_clk 40ns, recv_clk 100ns)
//  1. Pulse trans_rst -> fifo_empty=1, fifo_full=0, levels 0, recv_data=0x00, recv_valid=0.
//  2. Write 17..32 with no reads -> fifo_full=1 after 16th write, trans_level=16.
//     A 17th write (0x99) is dropped. Reads return 17..32 in order, then fifo_empty=1.
//  3. Fill one word at a time -> fifo_almost_full rises at trans_level=14.
//     Drain -> fifo_almost_empty rises once recv_level<=2.
//  4. Write 200 incrementing words, throttled by fifo_full, with continuous read_enable
//     -> 200 recv_valid beats, exact order, no loss or duplication.
//  5. Write 5 words, assert trans_rst mid-stream, then write 0x55
//     -> fifo_empty=1 during reset; first recv_data after reset is 0x55.
//  6. With ASYNC_FIFO_ERR_FLAGS_EN: write while full -> overflow=1.
//     Read while empty -> underflow=1. Both hold until trans_rst.

Source files
------------

// File: rtl/async_fifo_param.sv
// rtl/async_fifo_param.sv - dual-clock FIFO, trans_clk writes to recv_clk reads with Gray pointer crossing
// Optional overflow/underflow sticky flags when ASYNC_FIFO_ERR_FLAGS_EN is defined.
module async_fifo_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 2
) (
    input  logic                  recv_clk,
    input  logic                  trans_clk,
    input  logic                  trans_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] trans_data,
    output logic                  fifo_full,
    output logic                  fifo_almost_full,
    output logic [ADDR_WIDTH:0]   trans_level,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] recv_data,
    output logic                  recv_valid,
    output logic                  fifo_empty,
    output logic                  fifo_almost_empty,
    output logic [ADDR_WIDTH:0]   recv_level
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_MARGIN);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < PW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Reset asserts immediately in both domains; release is synchronised per domain.
    logic [SYNC_STAGES-1:0] wr_rst_pipe;
    logic [SYNC_STAGES-1:0] rd_rst_pipe;
    logic                   wr_rst;
    logic                   rd_rst;

    always_ff @(posedge trans_clk or posedge trans_rst) begin
        if (trans_rst) wr_rst_pipe <= '1;
        else           wr_rst_pipe <= {wr_rst_pipe[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge recv_clk or posedge trans_rst) begin
        if (trans_rst) rd_rst_pipe <= '1;
        else           rd_rst_pipe <= {rd_rst_pipe[SYNC_STAGES-2:0], 1'b0};
    end

    assign wr_rst = wr_rst_pipe[SYNC_STAGES-1];
    assign rd_rst = rd_rst_pipe[SYNC_STAGES-1];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [SYNC_STAGES-1:0][PW-1:0] rgray_pipe;
    logic [SYNC_STAGES-1:0][PW-1:0] wgray_pipe;
    logic [PW-1:0] rgray_sync, wgray_sync;
    logic [PW-1:0] trans_level_next, recv_level_next;
    logic          wr_accept, rd_accept, full_next, empty_next;

    // ---------------- write domain ----------------
    assign wr_accept        = write_enable && !fifo_full;
    assign wbin_next        = wbin + {{ADDR_WIDTH{1'b0}}, wr_accept};
    assign wgray_next       = wbin_next ^ (wbin_next >> 1);
    assign rgray_sync       = rgray_pipe[SYNC_STAGES-1];
    assign full_next        = (wgray_next == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});
    assign trans_level_next = wbin_next - gray2bin(rgray_sync);

    always_ff @(posedge trans_clk or posedge wr_rst) begin
        if (wr_rst) rgray_pipe <= '0;
        else        rgray_pipe <= {rgray_pipe[SYNC_STAGES-2:0], rgray};
    end

    always_ff @(posedge trans_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin             <= '0;
            wgray            <= '0;
            fifo_full        <= 1'b0;
            fifo_almost_full <= 1'b0;
            trans_level      <= '0;
        end else begin
            wbin             <= wbin_next;
            wgray            <= wgray_next;
            fifo_full        <= full_next;
            fifo_almost_full <= (trans_level_next >= AF_THRESH);
            trans_level      <= trans_level_next;
        end
    end

    // Storage is deliberately left uncleared by reset; pointers alone define contents.
    always_ff @(posedge trans_clk) begin
        if (wr_accept && !wr_rst) mem[wbin[ADDR_WIDTH-1:0]] <= trans_data;
    end

    // ---------------- read domain ----------------
    assign rd_accept       = read_enable && !fifo_empty;
    assign rbin_next       = rbin + {{ADDR_WIDTH{1'b0}}, rd_accept};
    assign rgray_next      = rbin_next ^ (rbin_next >> 1);
    assign wgray_sync      = wgray_pipe[SYNC_STAGES-1];
    assign empty_next      = (rgray_next == wgray_sync);
    assign recv_level_next = gray2bin(wgray_sync) - rbin_next;

    always_ff @(posedge recv_clk or posedge rd_rst) begin
        if (rd_rst) wgray_pipe <= '0;
        else        wgray_pipe <= {wgray_pipe[SYNC_STAGES-2:0], wgray};
    end

    always_ff @(posedge recv_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rbin              <= '0;
            rgray             <= '0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
            recv_level        <= '0;
            recv_valid        <= 1'b0;
            recv_data         <= '0;
        end else begin
            rbin              <= rbin_next;
            rgray             <= rgray_next;
            fifo_empty        <= empty_next;
            fifo_almost_empty <= (recv_level_next <= AE_THRESH);
            recv_level        <= recv_level_next;
            recv_valid        <= rd_accept;
            if (rd_accept) recv_data <= mem[rbin[ADDR_WIDTH-1:0]];
        end
    end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge trans_clk or posedge wr_rst) begin
        if (wr_rst)                          overflow <= 1'b0;
        else if (write_enable && fifo_full)  overflow <= 1'b1;
    end

    always_ff @(posedge recv_clk or posedge rd_rst) begin
        if (rd_rst)                          underflow <= 1'b0;
        else if (read_enable && fifo_empty)  underflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_async_fifo_param.sv
// tb/tb_async_fifo_param.sv - self-checking bench for async_fifo_param (scoreboard + fill/drain tables)
module tb_async_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int SYNC  = 2;
    localparam int DEPTH = 16;

    logic          recv_clk = 1'b0;
    logic          trans_clk = 1'b0;
    logic          trans_rst = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] trans_data = '0;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic [AW:0]   trans_level;
    logic          read_enable = 1'b0;
    logic [DW-1:0] recv_data;
    logic          recv_valid;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [AW:0]   recv_level;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    async_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AF_MARGIN(2), .AE_MARGIN(2)
    ) dut (
        .recv_clk(recv_clk),
        .trans_clk(trans_clk),
        .trans_rst(trans_rst),
        .write_enable(write_enable),
        .trans_data(trans_data),
        .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .trans_level(trans_level),
        .read_enable(read_enable),
        .recv_data(recv_data),
        .recv_valid(recv_valid),
        .fifo_empty(fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .recv_level(recv_level)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #20 trans_clk = ~trans_clk;
    always #50 recv_clk  = ~recv_clk;

    typedef struct {
        logic [DW-1:0] data;
        int            level;
        int            af;
        int            full;
    } fill_t;

    typedef struct {
        int level;
        int ae;
        int empty;
    } drain_t;

    fill_t         fill_tab  [DEPTH];
    drain_t        drain_tab [DEPTH];
    logic [DW-1:0] sb [$];
    int            n_pass  = 0;
    int            n_total = 0;
    int            beats   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        @(negedge trans_clk);
        write_enable = 1'b1;
        trans_data   = d;
        if (!fifo_full) sb.push_back(d);
        @(negedge trans_clk);
        write_enable = 1'b0;
    endtask

    task automatic rd();
        @(negedge recv_clk);
        read_enable = 1'b1;
        @(negedge recv_clk);
        read_enable = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_fifo_empty"},  fifo_empty, 1);
        check({tag, "_fifo_full"},   fifo_full, 0);
        check({tag, "_trans_level"}, trans_level, 0);
        check({tag, "_recv_level"},  recv_level, 0);
        check({tag, "_recv_data"},   recv_data, 0);
        check({tag, "_recv_valid"},  recv_valid, 0);
        check({tag, "_almost_empty"}, fifo_almost_empty, 1);
        check({tag, "_almost_full"},  fifo_almost_full, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int guard;
        int lat;

        for (int k = 0; k < DEPTH; k++) begin
            fill_tab[k].data   = DW'(17 + k);
            fill_tab[k].level  = k + 1;
            fill_tab[k].af     = (k + 1 >= DEPTH - 2) ? 1 : 0;
            fill_tab[k].full   = (k + 1 == DEPTH) ? 1 : 0;
            drain_tab[k].level = DEPTH - (k + 1);
            drain_tab[k].ae    = (DEPTH - (k + 1) <= 2) ? 1 : 0;
            drain_tab[k].empty = (k + 1 == DEPTH) ? 1 : 0;
        end

        // Output monitor: every recv_valid beat must match the oldest expected word.
        fork
            forever begin
                @(negedge recv_clk);
                if (recv_valid) begin
                    beats++;
                    if (sb.size() == 0) check("sb_underrun", 0, 1);
                    else                check("recv_data", recv_data, sb.pop_front());
                end
            end
        join_none

        // 1. reset
        #5 trans_rst = 1'b1;
        #30;
        reset_outputs("rst_during");
        #200 trans_rst = 1'b0;
        repeat (SYNC + 3) @(negedge recv_clk);
        reset_outputs("rst_after");

        // 2/3. fill one word at a time
        for (int k = 0; k < DEPTH; k++) begin
            wr(fill_tab[k].data);
            check($sformatf("fill%0d_level", k), trans_level, fill_tab[k].level);
            check($sformatf("fill%0d_af", k), fifo_almost_full, fill_tab[k].af);
            check($sformatf("fill%0d_full", k), fifo_full, fill_tab[k].full);
        end
        wr(8'h99);
        check("drop_level", trans_level, DEPTH);
        check("drop_full", fifo_full, 1);

        repeat (SYNC + 2) @(negedge recv_clk);
        check("sync_recv_level", recv_level, DEPTH);
        check("sync_empty", fifo_empty, 0);
        check("sync_almost_empty", fifo_almost_empty, 0);
        for (int k = 0; k < DEPTH; k++) begin
            rd();
            check($sformatf("drain%0d_level", k), recv_level, drain_tab[k].level);
            check($sformatf("drain%0d_ae", k), fifo_almost_empty, drain_tab[k].ae);
            check($sformatf("drain%0d_empty", k), fifo_empty, drain_tab[k].empty);
        end
        check("drain_sb_empty", sb.size(), 0);

        // 4. throttled stream with continuous reads
        @(negedge recv_clk);
        read_enable = 1'b1;
        beats = 0;
        idx   = 0;
        guard = 0;
        while (idx < 200 && guard < 5000) begin
            @(negedge trans_clk);
            guard++;
            trans_data   = DW'(idx);
            write_enable = 1'b1;
            if (!fifo_full) begin
                sb.push_back(DW'(idx));
                idx++;
            end
        end
        @(negedge trans_clk);
        write_enable = 1'b0;
        check("stream_words_sent", idx, 200);
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge recv_clk);
            guard++;
        end
        repeat (3) @(negedge recv_clk);
        read_enable = 1'b0;
        check("stream_beats", beats, 200);
        check("stream_sb_empty", sb.size(), 0);
        check("stream_empty", fifo_empty, 1);

        // 5. reset mid-stream
        for (int k = 0; k < 5; k++) wr(DW'(8'hA0 + k));
        @(negedge trans_clk);
        write_enable = 1'b1;
        trans_data   = 8'hA5;
        #7 trans_rst = 1'b1;
        #5;
        reset_outputs("midrst");
        sb.delete();
        write_enable = 1'b0;
        #300 trans_rst = 1'b0;
        repeat (SYNC + 3) @(negedge recv_clk);
        check("midrst_after_empty", fifo_empty, 1);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check("err_overflow_reset", overflow, 0);
        check("err_underflow_reset", underflow, 0);
`endif

        @(negedge trans_clk);
        write_enable = 1'b1;
        trans_data   = 8'h55;
        sb.push_back(8'h55);
        @(posedge trans_clk);
        #1 write_enable = 1'b0;
        lat = 0;
        while (fifo_empty && lat < 10) begin
            @(posedge recv_clk);
            #1 lat++;
        end
        check("first_word_latency", lat, SYNC + 1);
        beats = 0;
        rd();
        check("post_reset_beats", beats, 1);
        check("post_reset_sb_empty", sb.size(), 0);
        check("post_reset_empty", fifo_empty, 1);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        // 6. sticky error flags
        rd();
        check("err_underflow_set", underflow, 1);
        for (int k = 0; k <= DEPTH; k++) wr(DW'(k));
        check("err_overflow_set", overflow, 1);
        repeat (4) @(negedge recv_clk);
        check("err_underflow_hold", underflow, 1);
        check("err_overflow_hold", overflow, 1);
        @(negedge trans_clk);
        trans_rst = 1'b1;
        #5;
        sb.delete();
        check("err_overflow_clear", overflow, 0);
        check("err_underflow_clear", underflow, 0);
        #200 trans_rst = 1'b0;
        repeat (SYNC + 3) @(negedge recv_clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
